// File: rtl/serv_bus_arbiter.sv
// Shares one Wishbone master port between the instruction-fetch and data buses.
// Registered ownership FSM with a watchdog that completes hung cycles with a synthetic ack.
module serv_bus_arbiter #(
  parameter int unsigned DBUS_PRIO = 1,
  parameter int unsigned TO_W      = 8
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout
);

  localparam int unsigned CntW = (TO_W > 0) ? TO_W : 1;

  typedef enum logic [1:0] {StIdle, StIbus, StDbus} state_e;

  state_e          state_q, state_d;
  logic            last_dbus_q, last_dbus_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic owner_cyc;
  logic wd_hit;
  logic timeout;
  logic grant_dbus;
  logic wb_cyc;

  always_comb begin
    owner_cyc = 1'b0;
    unique case (state_q)
      StIbus:  owner_cyc = i_ibus_cyc;
      StDbus:  owner_cyc = i_dbus_cyc;
      default: owner_cyc = 1'b0;
    endcase
  end

  if (TO_W > 0) begin : g_wd
    assign wd_hit = &cnt_q;
  end else begin : g_no_wd
    assign wd_hit = 1'b0;
  end

  // A real ack in the same cycle as the watchdog hit takes precedence.
  assign timeout = owner_cyc & wd_hit & ~i_wb_ack;
  assign wb_cyc  = owner_cyc & ~timeout;

  always_comb begin
    if (i_ibus_cyc && i_dbus_cyc) begin
      grant_dbus = (DBUS_PRIO != 0) ? 1'b1 : ~last_dbus_q;
    end else begin
      grant_dbus = i_dbus_cyc;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      last_dbus_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_dbus_q <= last_dbus_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_dbus_d = last_dbus_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (i_ibus_cyc || i_dbus_cyc) begin
          state_d     = grant_dbus ? StDbus : StIbus;
          last_dbus_d = grant_dbus;
        end
      end
      StIbus, StDbus: begin
        cnt_d = cnt_q + CntW'(1);
        // Ack, watchdog or an abandoned request all release the port.
        if (!owner_cyc || i_wb_ack || timeout) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    o_wb_cyc   = wb_cyc;
    o_timeout  = timeout;
    o_ibus_ack = (state_q == StIbus) & ((i_wb_ack & wb_cyc) | timeout);
    o_dbus_ack = (state_q == StDbus) & ((i_wb_ack & wb_cyc) | timeout);
    o_ibus_rdt = timeout ? 32'h0 : i_wb_rdt;
    o_dbus_rdt = timeout ? 32'h0 : i_wb_rdt;
    if (state_q == StIbus) begin
      o_wb_adr = i_ibus_adr;
      o_wb_dat = 32'h0;
      o_wb_sel = 4'hF;
      o_wb_we  = 1'b0;
    end else begin
      o_wb_adr = i_dbus_adr;
      o_wb_dat = i_dbus_dat;
      o_wb_sel = i_dbus_sel;
      o_wb_we  = i_dbus_we;
    end
  end

  a_one_ack: assert property (@(posedge clk) disable iff (!i_rst_n)
    !(o_ibus_ack && o_dbus_ack));
  a_idle_no_cyc: assert property (@(posedge clk) disable iff (!i_rst_n)
    (state_q == StIdle) |-> !o_wb_cyc);

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Bench for serv_bus_arbiter: directed scenarios followed by random traffic,
// all cycles compared against a transaction-level ownership model.
module tb_serv_bus_arbiter;

  localparam int TO_LIMIT = 15;  // 2^4 - 1 for TO_W = 4

  logic        clk;
  logic        rst_n;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;

  logic [31:0] o_ibus_rdt, o_dbus_rdt, o_wb_adr, o_wb_dat;
  logic        o_ibus_ack, o_dbus_ack, o_wb_we, o_wb_cyc, o_timeout;
  logic [3:0]  o_wb_sel;

  logic [31:0] b_ibus_rdt, b_dbus_rdt, b_wb_adr, b_wb_dat;
  logic        b_ibus_ack, b_dbus_ack, b_wb_we, b_wb_cyc, b_timeout;
  logic [3:0]  b_wb_sel;

  int checks   = 0;
  int failures = 0;

  // Model state: owner 0 = none, 1 = ibus, 2 = dbus.
  int   m_owner;
  int   m_wait;
  logic m_last_d;
  logic m_iack;
  logic m_dack;

  serv_bus_arbiter #(.DBUS_PRIO(0), .TO_W(4)) u_dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_ibus_adr (ibus_adr),
    .i_ibus_cyc (ibus_cyc),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .i_dbus_adr (dbus_adr),
    .i_dbus_dat (dbus_dat),
    .i_dbus_sel (dbus_sel),
    .i_dbus_we  (dbus_we),
    .i_dbus_cyc (dbus_cyc),
    .o_dbus_rdt (o_dbus_rdt),
    .o_dbus_ack (o_dbus_ack),
    .o_wb_adr   (o_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),
    .o_wb_cyc   (o_wb_cyc),
    .i_wb_rdt   (wb_rdt),
    .i_wb_ack   (wb_ack),
    .o_timeout  (o_timeout)
  );

  serv_bus_arbiter #(.DBUS_PRIO(1), .TO_W(4)) u_dut_prio (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_ibus_adr (ibus_adr),
    .i_ibus_cyc (ibus_cyc),
    .o_ibus_rdt (b_ibus_rdt),
    .o_ibus_ack (b_ibus_ack),
    .i_dbus_adr (dbus_adr),
    .i_dbus_dat (dbus_dat),
    .i_dbus_sel (dbus_sel),
    .i_dbus_we  (dbus_we),
    .i_dbus_cyc (dbus_cyc),
    .o_dbus_rdt (b_dbus_rdt),
    .o_dbus_ack (b_dbus_ack),
    .o_wb_adr   (b_wb_adr),
    .o_wb_dat   (b_wb_dat),
    .o_wb_sel   (b_wb_sel),
    .o_wb_we    (b_wb_we),
    .o_wb_cyc   (b_wb_cyc),
    .i_wb_rdt   (wb_rdt),
    .i_wb_ack   (wb_ack),
    .o_timeout  (b_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the DUT against the model at the falling edge, advance the model,
  // then return just after the next rising edge.
  task automatic cycle();
    logic own_cyc, fire, e_cyc, e_iack, e_dack, grant_d;
    @(negedge clk);
    if (!rst_n) begin
      chk("reset_outputs", 64'({o_wb_cyc, o_ibus_ack, o_dbus_ack, o_timeout}), 64'(0));
      m_owner  = 0;
      m_wait   = 0;
      m_last_d = 1'b1;
      m_iack   = 1'b0;
      m_dack   = 1'b0;
    end else begin
      own_cyc = (m_owner == 1) ? ibus_cyc : (m_owner == 2) ? dbus_cyc : 1'b0;
      fire    = own_cyc && (m_wait == TO_LIMIT) && !wb_ack;
      e_cyc   = own_cyc && !fire;
      e_iack  = (m_owner == 1) && ((own_cyc && wb_ack) || fire);
      e_dack  = (m_owner == 2) && ((own_cyc && wb_ack) || fire);
      chk("model_cyc", 64'(o_wb_cyc), 64'(e_cyc));
      chk("model_acks", 64'({o_ibus_ack, o_dbus_ack, o_timeout}),
          64'({e_iack, e_dack, fire}));
      if (e_cyc) begin
        chk("model_adr", 64'(o_wb_adr), 64'((m_owner == 1) ? ibus_adr : dbus_adr));
        chk("model_ctl", 64'({o_wb_we, o_wb_sel, o_wb_dat}),
            (m_owner == 1) ? 64'({1'b0, 4'hF, 32'h0}) : 64'({dbus_we, dbus_sel, dbus_dat}));
      end
      if (e_iack) chk("model_irdt", 64'(o_ibus_rdt), fire ? 64'(0) : 64'(wb_rdt));
      if (e_dack) chk("model_drdt", 64'(o_dbus_rdt), fire ? 64'(0) : 64'(wb_rdt));
      m_iack = e_iack;
      m_dack = e_dack;
      if (m_owner == 0) begin
        if (ibus_cyc || dbus_cyc) begin
          grant_d  = (ibus_cyc && dbus_cyc) ? !m_last_d : dbus_cyc;
          m_owner  = grant_d ? 2 : 1;
          m_last_d = grant_d;
          m_wait   = 0;
        end
      end else if (!own_cyc || wb_ack || fire) begin
        m_owner = 0;
      end else begin
        m_wait++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    rst_n    = 1'b0;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    wb_rdt   = '0; wb_ack = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;

    // ibus read, slave acks on the third owner cycle
    ibus_adr = 32'h100; ibus_cyc = 1'b1;
    #1 chk("t1_idle_cyc", 64'(o_wb_cyc), 64'(0));
    cycle();
    #1 chk("t1_cyc_adr", 64'({o_wb_cyc, o_wb_adr}), 64'({1'b1, 32'h100}));
    cycle();
    cycle();
    wb_ack = 1'b1; wb_rdt = 32'hDEADBEEF;
    #1 chk("t1_ack", 64'({o_ibus_ack, o_dbus_ack, o_ibus_rdt}), 64'({2'b10, 32'hDEADBEEF}));
    cycle();
    wb_ack = 1'b0; ibus_cyc = 1'b0;
    #1 chk("t1_back_idle", 64'(o_wb_cyc), 64'(0));
    cycle();

    // dbus write
    dbus_adr = 32'h2000; dbus_dat = 32'h12345678; dbus_sel = 4'b0011; dbus_we = 1'b1;
    dbus_cyc = 1'b1;
    cycle();
    #1 chk("t2_write_bus", 64'({o_wb_cyc, o_wb_we, o_wb_sel, o_wb_dat}),
           64'({1'b1, 1'b1, 4'h3, 32'h12345678}));
    cycle();
    wb_ack = 1'b1;
    #1 chk("t2_ack", 64'({o_ibus_ack, o_dbus_ack}), 64'(2'b01));
    cycle();
    wb_ack = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0;
    #1 chk("t2_single_ack", 64'({o_dbus_ack, o_wb_cyc}), 64'(0));
    cycle();

    // both held, slave always acking: round-robin alternates, fixed prio keeps dbus
    ibus_adr = 32'h400; dbus_adr = 32'h500; ibus_cyc = 1'b1; dbus_cyc = 1'b1; wb_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t3_rr_acks", 64'({o_ibus_ack, o_dbus_ack}), 64'({k % 4 == 1, k % 4 == 3}));
      chk("t3_prio_acks", 64'({b_ibus_ack, b_dbus_ack}), 64'({1'b0, k % 2 == 1}));
      cycle();
    end
    ibus_cyc = 1'b0; dbus_cyc = 1'b0; wb_ack = 1'b0;
    cycle();

    // watchdog fires on the owner cycle after 15 ack-less cycles
    dbus_adr = 32'h600; dbus_cyc = 1'b1; wb_rdt = 32'hAAAA5555;
    cycle();
    for (int k = 0; k < TO_LIMIT; k++) cycle();
    #1 chk("t4_timeout", 64'({o_timeout, o_dbus_ack, o_wb_cyc, o_dbus_rdt}),
           64'({3'b110, 32'h0}));
    cycle();
    dbus_cyc = 1'b0;
    #1 chk("t4_after", 64'({o_timeout, o_wb_cyc}), 64'(0));
    cycle();
    dbus_cyc = 1'b1;
    cycle();
    for (int k = 0; k < TO_LIMIT; k++) cycle();
    wb_ack = 1'b1; wb_rdt = 32'hCAFEF00D;
    #1 chk("t4_ack_wins", 64'({o_timeout, o_dbus_ack, o_dbus_rdt}), 64'({2'b01, 32'hCAFEF00D}));
    cycle();
    dbus_cyc = 1'b0; wb_ack = 1'b0;
    cycle();

    // ibus abort, late ack ignored
    ibus_adr = 32'h300; ibus_cyc = 1'b1;
    cycle();
    cycle();
    cycle();
    ibus_cyc = 1'b0;
    #1 chk("t5_abort_cyc", 64'(o_wb_cyc), 64'(0));
    cycle();
    wb_ack = 1'b1;
    #1 chk("t5_late_ack", 64'({o_ibus_ack, o_dbus_ack, o_wb_cyc}), 64'(0));
    cycle();
    wb_ack = 1'b0;

    // async reset during a dbus cycle, pending ibus served afterwards
    dbus_adr = 32'h700; dbus_cyc = 1'b1;
    cycle();
    ibus_adr = 32'h800; ibus_cyc = 1'b1; wb_ack = 1'b1;
    #1 chk("t6_pre_reset", 64'({o_wb_cyc, o_dbus_ack}), 64'(2'b11));
    rst_n = 1'b0;
    #1 chk("t6_async_drop", 64'({o_wb_cyc, o_dbus_ack}), 64'(0));
    cycle();
    rst_n = 1'b1; dbus_cyc = 1'b0; wb_ack = 1'b0;
    #1 chk("t6_idle", 64'(o_wb_cyc), 64'(0));
    cycle();
    wb_ack = 1'b1;
    #1 chk("t6_ibus_grant", 64'({o_wb_cyc, o_ibus_ack, o_wb_adr}), 64'({2'b11, 32'h800}));
    cycle();
    ibus_cyc = 1'b0; wb_ack = 1'b0;
    cycle();

    // random traffic with phases of prompt, slow and nearly absent slave acks
    p = 70;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(2))
          0:       p = 70;
          1:       p = 25;
          default: p = 2;
        endcase
      end
      wb_ack = ($urandom_range(99) < p);
      wb_rdt = $urandom();
      if (ibus_cyc) begin
        if (m_iack) begin
          if ($urandom_range(1) == 0) ibus_cyc = 1'b0;
          else ibus_adr = $urandom();
        end else if ($urandom_range(49) == 0) begin
          ibus_cyc = 1'b0;
        end
      end else if ($urandom_range(99) < 40) begin
        ibus_cyc = 1'b1;
        ibus_adr = $urandom();
      end
      if (dbus_cyc) begin
        if (m_dack) begin
          if ($urandom_range(1) == 0) dbus_cyc = 1'b0;
          else begin
            dbus_adr = $urandom(); dbus_dat = $urandom();
            dbus_sel = 4'($urandom()); dbus_we = 1'($urandom());
          end
        end else if ($urandom_range(49) == 0) begin
          dbus_cyc = 1'b0;
        end
      end else if ($urandom_range(99) < 40) begin
        dbus_cyc = 1'b1;
        dbus_adr = $urandom(); dbus_dat = $urandom();
        dbus_sel = 4'($urandom()); dbus_we = 1'($urandom());
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
